// File: rtl/heap_feeder.sv
// heap_feeder: accepts scored items upstream, packs them into heap words and
// sequences init / paced insertion / flush / drain for one top-K heap frame.
module heap_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 16,
  parameter int NLEVELS    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic                            s_valid_i,
  output logic                            s_ready_o,
  input  logic [KEY_WIDTH-1:0]            s_key_i,
  input  logic [DATA_WIDTH-KEY_WIDTH-3:0] s_payload_i,
  input  logic                            s_last_i,
  output logic [DATA_WIDTH-1:0]           heap_din_o,
  output logic                            heap_en_o,
  output logic                            heap_init_o,
  output logic                            heap_flush_o,
  input  logic                            heap_valid_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [CNT_WIDTH-1:0]            in_count_o,
  output logic [CNT_WIDTH-1:0]            out_count_o
);

  localparam int HEAP_SIZE    = 2**(NLEVELS+1) - 1;
  localparam int DRAIN_CYCLES = 2*HEAP_SIZE + 8;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES);

  // state | meaning
  // IDLE  | waiting for start      INIT  | heap_init pulse      FEED | paced inserts
  // FLUSH | heap_flush next cycle  DRAIN | wait for heap output DONE | done pulse next cycle
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    phase_q, phase_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    en_q, en_d;
  logic                    init_q, init_d;
  logic                    flush_q, flush_d;
  logic                    done_q, done_d;
  logic [CNT_WIDTH-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0]    out_cnt_q, out_cnt_d;
  logic                    handshake;
  logic                    counting;

  assign s_ready_o    = (state_q == S_FEED) && !phase_q;
  assign handshake    = s_valid_i && s_ready_o;
  assign counting     = (state_q == S_FEED) || (state_q == S_FLUSH) || (state_q == S_DRAIN);

  assign heap_din_o   = din_q;
  assign heap_en_o    = en_q;
  assign heap_init_o  = init_q;
  assign heap_flush_o = flush_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign in_count_o   = in_cnt_q;
  assign out_count_o  = out_cnt_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    drain_d   = drain_q;
    din_d     = din_q;
    en_d      = 1'b0;
    init_d    = 1'b0;
    flush_d   = 1'b0;
    done_d    = 1'b0;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;

    // Abort leaves the heap cleared so a stale partial frame never leaks out.
    if (state_q != S_IDLE && abort_i) begin
      state_d = S_IDLE;
      init_d  = 1'b1;
    end else begin
      if (counting && heap_valid_i && !(&out_cnt_q)) begin
        out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            state_d   = S_INIT;
            init_d    = 1'b1;
            in_cnt_d  = '0;
            out_cnt_d = '0;
          end
        end
        S_INIT: begin
          state_d = S_FEED;
          phase_d = 1'b0;
        end
        S_FEED: begin
          phase_d = !phase_q;
          if (handshake) begin
            en_d  = 1'b1;
            din_d = {2'b00, s_payload_i, s_key_i};
            if (!(&in_cnt_q)) begin
              in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
            end
            if (s_last_i) begin
              state_d = S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          flush_d = 1'b1;
          state_d = S_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
        end
        S_DRAIN: begin
          if (drain_q == '0) begin
            state_d = S_DONE;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      drain_q   <= '0;
      din_q     <= '0;
      en_q      <= 1'b0;
      init_q    <= 1'b0;
      flush_q   <= 1'b0;
      done_q    <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      drain_q   <= drain_d;
      din_q     <= din_d;
      en_q      <= en_d;
      init_q    <= init_d;
      flush_q   <= flush_d;
      done_q    <= done_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_heap_feeder.sv
// Directed bench for heap_feeder: frame timing, paced inserts, counters,
// abort and reset behaviour, all against hand-derived expectations.
module tb_heap_feeder;

  localparam int DW = 32;
  localparam int KW = 16;
  localparam int PW = DW - KW - 2;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [KW-1:0] s_key_i = '0;
  logic [PW-1:0] s_payload_i = '0;
  logic          s_last_i = 1'b0;
  logic [DW-1:0] heap_din_o;
  logic          heap_en_o;
  logic          heap_init_o;
  logic          heap_flush_o;
  logic          heap_valid_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] in_count_o;
  logic [CW-1:0] out_count_o;

  heap_feeder dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_key_i      (s_key_i),
    .s_payload_i  (s_payload_i),
    .s_last_i     (s_last_i),
    .heap_din_o   (heap_din_o),
    .heap_en_o    (heap_en_o),
    .heap_init_o  (heap_init_o),
    .heap_flush_o (heap_flush_o),
    .heap_valid_i (heap_valid_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .in_count_o   (in_count_o),
    .out_count_o  (out_count_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] pack(input logic [PW-1:0] p, input logic [KW-1:0] k);
    return {2'b00, p, k};
  endfunction

  function automatic logic [KW-1:0] key_of(input int i);
    return KW'(i * 37 + 5);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_din"},   heap_din_o, 0);
    chk({tag, "_en"},    heap_en_o, 0);
    chk({tag, "_init"},  heap_init_o, 0);
    chk({tag, "_flush"}, heap_flush_o, 0);
    chk({tag, "_ready"}, s_ready_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_done"},  done_o, 0);
    chk({tag, "_inc"},   in_count_o, 0);
    chk({tag, "_outc"},  out_count_o, 0);
  endtask

  logic [DW-1:0] exp_q[$];
  int            n, idx, guard, cnt_a, cnt_b;
  logic          prev_en, acc;

  initial begin
    // ---------------- reset ----------------
    step();
    step();
    chk_all_zero("rst");
    rstn_i = 1'b1;
    step();
    chk("idle_busy", busy_o, 0);
    chk("idle_ready", s_ready_o, 0);

    // ---------------- frame 1: keys 10,3,7 ----------------
    start_i = 1'b1;
    step();
    chk("f1_init", heap_init_o, 1);
    chk("f1_init_busy", busy_o, 1);
    chk("f1_init_ready", s_ready_o, 0);
    start_i = 1'b0;
    s_valid_i = 1'b1; s_key_i = 16'd10; s_payload_i = 14'h005A;
    step();
    chk("f1_init_one_cycle", heap_init_o, 0);
    chk("f1_first_ready", s_ready_o, 1);
    step();
    chk("f1_en1", heap_en_o, 1);
    chk("f1_din1", heap_din_o, pack(14'h005A, 16'd10));
    chk("f1_cnt1", in_count_o, 1);
    chk("f1_ready_gap", s_ready_o, 0);
    s_key_i = 16'd3;
    step();
    chk("f1_gap1", heap_en_o, 0);
    chk("f1_din_hold", heap_din_o, pack(14'h005A, 16'd10));
    step();
    chk("f1_en2", heap_en_o, 1);
    chk("f1_din2", heap_din_o, pack(14'h005A, 16'd3));
    s_key_i = 16'd7; s_last_i = 1'b1;
    step();
    chk("f1_gap2", heap_en_o, 0);
    step();
    chk("f1_en3", heap_en_o, 1);
    chk("f1_din3", heap_din_o, pack(14'h005A, 16'd7));
    chk("f1_cnt3", in_count_o, 3);
    chk("f1_ready_after_last", s_ready_o, 0);
    s_valid_i = 1'b0; s_last_i = 1'b0;
    step();
    chk("f1_flush", heap_flush_o, 1);
    chk("f1_no_en", heap_en_o, 0);
    step();
    chk("f1_flush_one_cycle", heap_flush_o, 0);
    n = 1;
    while (!done_o && n < 300) begin
      step();
      n++;
    end
    chk("f1_done_latency", n, 71);
    chk("f1_done_cnt", in_count_o, 3);
    chk("f1_done_busy", busy_o, 0);
    step();
    chk("f1_done_one_cycle", done_o, 0);
    chk("f1_cnt_hold", in_count_o, 3);

    // ---------------- frame 2: 40 items, random valid, heap_valid 9+31 ----------------
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("f2_init", heap_init_o, 1);
    chk("f2_cnt_clear", in_count_o, 0);
    acc = 1'b0; idx = 0; guard = 0; prev_en = 1'b0;
    while (!(idx == 40 && exp_q.size() == 0) && guard < 2000) begin
      step();
      if (heap_en_o) begin
        chk("f2_spacing", prev_en, 0);
        if (exp_q.size() != 0) chk("f2_din", heap_din_o, exp_q.pop_front());
        else chk("f2_extra_en", heap_en_o, 0);
      end
      prev_en = heap_en_o;
      heap_valid_i = (guard < 9);
      if (idx < 40) begin
        if (!s_valid_i || acc) s_valid_i = 1'($urandom_range(0, 1));
        s_key_i = key_of(idx);
        s_payload_i = PW'(idx + 100);
        s_last_i = (idx == 39);
        acc = s_valid_i && s_ready_o;
        if (acc) begin
          exp_q.push_back(pack(PW'(idx + 100), key_of(idx)));
          idx++;
        end
      end else begin
        s_valid_i = 1'b0; s_last_i = 1'b0; acc = 1'b0;
      end
      guard++;
    end
    chk("f2_items_sent", idx, 40);
    chk("f2_sb_empty", exp_q.size(), 0);
    chk("f2_in_count", in_count_o, 40);
    heap_valid_i = 1'b0;
    step();
    chk("f2_flush", heap_flush_o, 1);
    heap_valid_i = 1'b1;
    for (int i = 0; i < 31; i++) step();
    heap_valid_i = 1'b0;
    n = 0;
    while (!done_o && n < 200) begin
      step();
      n++;
    end
    chk("f2_done", done_o, 1);
    chk("f2_out_count", out_count_o, 40);
    chk("f2_in_count_done", in_count_o, 40);

    // ---------------- abort after 5 items ----------------
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    s_valid_i = 1'b1; s_key_i = 16'h1234; s_payload_i = 14'h0011;
    cnt_a = 0; n = 0;
    while (cnt_a < 5 && n < 100) begin
      step();
      n++;
      if (heap_en_o) cnt_a++;
    end
    chk("ab_five_items", in_count_o, 5);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0; s_valid_i = 1'b0;
    chk("ab_busy", busy_o, 0);
    chk("ab_init", heap_init_o, 1);
    chk("ab_en", heap_en_o, 0);
    chk("ab_cnt", in_count_o, 5);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 90; i++) begin
      step();
      if (heap_flush_o) cnt_a++;
      if (done_o) cnt_b++;
    end
    chk("ab_no_flush", cnt_a, 0);
    chk("ab_no_done", cnt_b, 0);
    chk("ab_cnt_hold", in_count_o, 5);

    // ---------------- abort together with accepted s_last ----------------
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    s_valid_i = 1'b1; s_last_i = 1'b1; s_key_i = 16'd99;
    n = 0;
    while (!s_ready_o && n < 10) begin
      step();
      n++;
    end
    chk("al_ready", s_ready_o, 1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0; s_valid_i = 1'b0; s_last_i = 1'b0;
    chk("al_no_en", heap_en_o, 0);
    chk("al_busy", busy_o, 0);
    chk("al_init", heap_init_o, 1);
    chk("al_cnt", in_count_o, 0);
    step();
    chk("al_no_flush", heap_flush_o, 0);
    chk("al_init_one_cycle", heap_init_o, 0);

    // ---------------- start during DRAIN is ignored ----------------
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    s_valid_i = 1'b1; s_last_i = 1'b1; s_key_i = 16'd1; s_payload_i = 14'h0001;
    n = 0;
    while (!heap_en_o && n < 10) begin
      step();
      n++;
    end
    chk("sd_en", heap_en_o, 1);
    s_valid_i = 1'b0; s_last_i = 1'b0;
    step();
    chk("sd_flush", heap_flush_o, 1);
    for (int i = 0; i < 5; i++) step();
    start_i = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      start_i = 1'b0;
      if (done_o) cnt_a++;
      if (heap_init_o) cnt_b++;
    end
    chk("sd_single_done", cnt_a, 1);
    chk("sd_no_init", cnt_b, 0);
    chk("sd_cnt", in_count_o, 1);
    chk("sd_idle", busy_o, 0);

    // ---------------- start with abort in IDLE ----------------
    start_i = 1'b1; abort_i = 1'b1;
    step();
    start_i = 1'b0; abort_i = 1'b0;
    chk("sa_busy", busy_o, 0);
    chk("sa_init", heap_init_o, 0);
    step();
    chk("sa_busy2", busy_o, 0);

    // ---------------- reset mid-FEED ----------------
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    s_valid_i = 1'b1; s_key_i = 16'hBEEF; s_payload_i = 14'h0ABC;
    cnt_a = 0; n = 0;
    while (cnt_a < 2 && n < 50) begin
      step();
      n++;
      if (heap_en_o) cnt_a++;
    end
    chk("mr_pre_cnt", in_count_o, 2);
    rstn_i = 1'b0;
    #1;
    chk_all_zero("mr_async");
    step();
    chk_all_zero("mr_held");
    rstn_i = 1'b1;
    step();
    step();
    chk("mr_no_reinit", heap_init_o, 0);
    chk("mr_idle", busy_o, 0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("mr_init", heap_init_o, 1);
    chk("mr_cnt0", in_count_o, 0);
    n = 0;
    while (!heap_en_o && n < 10) begin
      step();
      n++;
    end
    chk("mr_en", heap_en_o, 1);
    chk("mr_din", heap_din_o, pack(14'h0ABC, 16'hBEEF));
    chk("mr_cnt1", in_count_o, 1);
    s_valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
